// File: rtl/easyaxi_pkg.sv
// Shared types and AXI response codes for the EasyAXI master scheduler.
package easyaxi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_DRAIN = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_DRAIN = 3'd4,
    ST_DONE     = 3'd5,
    ST_ABORT    = 3'd6
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/easyaxi_ost_cnt.sv
// Outstanding-transaction up/down counter; a decrement while empty is dropped and flagged.
module easyaxi_ost_cnt
  import easyaxi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          empty_o,
  output logic          full_nxt_c,
  output logic          underflow_c
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q;
  logic          dec_ok;

  assign underflow_c = dec_i & (cnt_q == '0);
  assign dec_ok      = dec_i & ~underflow_c;

  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign full_nxt_c = (cnt_d == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
    end
  end

  assign cnt_o   = cnt_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/easyaxi_mst_sched.sv
// EasyAXI master transaction scheduler: write phase, drain, read phase to the same
// addresses, with an outstanding cap and completion error accounting.
module easyaxi_mst_sched
  import easyaxi_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           TXN_NUM    = 16,
  parameter int unsigned           OST_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(32'h40),
  parameter int unsigned           BURST_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [7:0]            req_len,
  output logic [ID_WIDTH-1:0]   req_id,
  input  logic                  cpl_valid,
  input  logic                  cpl_write,
  input  logic [1:0]            cpl_resp,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int unsigned IW = $clog2(TXN_NUM + 1);
  localparam int unsigned OW = $clog2(OST_DEPTH + 1);

  state_e                state_q;
  logic                  enable_q;
  logic [IW-1:0]         issue_cnt_q;
  logic                  req_valid_q, req_write_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [7:0]            req_len_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;

  logic          hs, hold, last, start;
  logic [OW-1:0] ost_cnt;
  logic          ost_empty, ost_full_nxt, ost_unf;
  logic          phase_wr, phase_rd, resp_err, type_err;
  logic [1:0]    err_inc;
  logic [ERR_CNT_W:0] err_sum;

  assign hs    = req_valid_q & req_ready;
  assign hold  = req_valid_q & ~req_ready;
  assign last  = (issue_cnt_q == IW'(TXN_NUM - 1));
  assign start = (state_q == ST_IDLE) & enable & ~enable_q;

  easyaxi_ost_cnt #(.DEPTH(OST_DEPTH)) u_ost (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (hs),
    .dec_i       (cpl_valid),
    .cnt_o       (ost_cnt),
    .empty_o     (ost_empty),
    .full_nxt_c  (ost_full_nxt),
    .underflow_c (ost_unf)
  );

  // Sequencer; the running address register replaces a base+index*stride multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      enable_q    <= 1'b0;
      issue_cnt_q <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      enable_q <= enable;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q     <= ST_WR_ISSUE;
          issue_cnt_q <= '0;
          req_addr_q  <= ADDR_BASE;
          req_write_q <= 1'b1;
          req_len_q   <= 8'(BURST_LEN);
          req_valid_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        ST_WR_ISSUE, ST_RD_ISSUE: begin
          if (hs) begin
            issue_cnt_q <= issue_cnt_q + IW'(1);
            req_addr_q  <= req_addr_q + ADDR_STEP;
          end
          if (!enable && !hold) begin
            state_q     <= ST_ABORT;
            req_valid_q <= 1'b0;
          end else if (hs && last) begin
            state_q     <= (state_q == ST_WR_ISSUE) ? ST_WR_DRAIN : ST_RD_DRAIN;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= hold | ~ost_full_nxt;
          end
        end
        ST_WR_DRAIN: if (ost_empty) begin
          state_q     <= ST_RD_ISSUE;
          issue_cnt_q <= '0;
          req_addr_q  <= ADDR_BASE;
          req_write_q <= 1'b0;
          req_valid_q <= 1'b1;
        end
        ST_RD_DRAIN: if (ost_empty) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: if (!enable) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        ST_ABORT: if (ost_cnt == '0) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A stray completion counts once and is otherwise ignored.
  assign phase_wr = (state_q == ST_WR_ISSUE) | (state_q == ST_WR_DRAIN);
  assign phase_rd = (state_q == ST_RD_ISSUE) | (state_q == ST_RD_DRAIN);
  assign resp_err = cpl_valid & (cpl_resp inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR});
  assign type_err = cpl_valid & ((phase_wr & ~cpl_write) | (phase_rd & cpl_write));
  assign err_inc  = ost_unf ? 2'd1 : (2'(resp_err) + 2'(type_err));
  assign err_sum  = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(err_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (start) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (err_inc != 2'd0) begin
      err_q     <= 1'b1;
      err_cnt_q <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end
  end

  assign req_valid = req_valid_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_len   = req_len_q;
  assign req_id    = ID_WIDTH'(issue_cnt_q);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_easyaxi_mst_sched.sv
// Bench for easyaxi_mst_sched: transaction-level model with per-cycle compare plus directed scenarios.
module tb_easyaxi_mst_sched;

  localparam int unsigned AW   = 32;
  localparam int unsigned IDW  = 4;
  localparam int unsigned TXN  = 4;
  localparam int unsigned OST  = 2;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] STEP = 32'h40;
  localparam int unsigned BLEN = 3;

  logic          clk, rst, enable, req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic [IDW-1:0] req_id;
  logic          cpl_valid, cpl_write;
  logic [1:0]    cpl_resp;
  logic          busy, done, err;
  logic [15:0]   err_cnt;

  easyaxi_mst_sched #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .TXN_NUM(TXN), .OST_DEPTH(OST),
    .ADDR_BASE(BASE), .ADDR_STEP(STEP), .BURST_LEN(BLEN)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_id(req_id),
    .cpl_valid(cpl_valid), .cpl_write(cpl_write), .cpl_resp(cpl_resp),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  int          cyc = 0;
  int          m_ost, m_errs, n_wr_hs, n_rd_hs;
  bit          m_last_wr, en_prev, prev_hold, done_seen, both_at1;
  logic [31:0] prev_addr;
  logic [3:0]  prev_id;
  logic        prev_wr;
  logic [31:0] log_addr[$];
  bit          log_wr[$];
  int          due_q[$];
  bit          type_q[$];
  logic [1:0]  resp_q[$];

  // Stimulus knobs
  int cpl_delay = 2;
  int bad_idx   = -1;
  bit cpl_hold  = 1'b0;
  bit stray_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare against the model, then advance the model by what the next edge will see.
  always @(negedge clk) begin
    if (rst) begin
      m_ost = 0; m_errs = 0; n_wr_hs = 0; n_rd_hs = 0;
      m_last_wr = 1'b0; en_prev = 1'b0; prev_hold = 1'b0; done_seen = 1'b0;
      due_q.delete(); type_q.delete(); resp_q.delete();
    end else begin
      bit hs, stray, ew, st;
      int idx, inc, ost_before;
      chk("ost_cnt", 64'(dut.u_ost.cnt_o), 64'(m_ost));
      chk("err_cnt", 64'(err_cnt), 64'(m_errs));
      chk("err", 64'(err), 64'(m_errs != 0));
      if (prev_hold) begin
        chk("hold_valid", 64'(req_valid), 64'd1);
        chk("hold_addr", 64'(req_addr), 64'(prev_addr));
        chk("hold_id", 64'(req_id), 64'(prev_id));
        chk("hold_write", 64'(req_write), 64'(prev_wr));
      end
      if (req_valid) begin
        ew  = (n_wr_hs < TXN);
        idx = ew ? n_wr_hs : n_rd_hs;
        chk("req_write", 64'(req_write), 64'(ew));
        chk("req_addr", 64'(req_addr), 64'(BASE + 32'(idx) * STEP));
        chk("req_id", 64'(req_id), 64'(idx % 16));
        chk("req_len", 64'(req_len), 64'(BLEN));
        chk("ost_room", 64'(m_ost < OST), 64'd1);
        if (!ew && n_rd_hs == 0) chk("rd_after_drain", 64'(m_ost), 64'd0);
      end
      if (done) begin
        done_seen = 1'b1;
        chk("done_complete", 64'(n_rd_hs == TXN && m_ost == 0), 64'd1);
      end

      hs = req_valid && req_ready;
      st = enable && !en_prev;
      ost_before = m_ost;
      if (st) begin
        m_errs = 0; n_wr_hs = 0; n_rd_hs = 0; done_seen = 1'b0;
        log_addr.delete(); log_wr.delete();
      end
      stray = cpl_valid && (m_ost == 0);
      if (cpl_valid) begin
        inc = stray ? 1 : (int'(cpl_resp != 2'b00) + int'(cpl_write != m_last_wr));
        if (!st) m_errs = m_errs + inc;
      end
      m_ost = m_ost + int'(hs) - int'(cpl_valid && !stray);
      if (hs) begin
        if (cpl_valid && ost_before == 1) both_at1 = 1'b1;
        log_addr.push_back(req_addr);
        log_wr.push_back(req_write);
        due_q.push_back(cyc + 1 + cpl_delay);
        type_q.push_back(req_write);
        resp_q.push_back((req_write && n_wr_hs == bad_idx) ? 2'b10 : 2'b00);
        if (req_write) n_wr_hs++; else n_rd_hs++;
        m_last_wr = req_write;
      end
      prev_hold = req_valid && !req_ready;
      prev_addr = req_addr; prev_id = req_id; prev_wr = req_write;
      en_prev   = enable;
    end
  end

  // Completion responder: in-order, one per cycle, after the configured delay.
  initial begin
    cpl_valid = 1'b0; cpl_write = 1'b0; cpl_resp = 2'b00;
    forever begin
      @(posedge clk); #2;
      cpl_valid = 1'b0; cpl_write = 1'b0; cpl_resp = 2'b00;
      if (!rst) begin
        if (!cpl_hold && due_q.size() > 0 && due_q[0] <= cyc + 1) begin
          void'(due_q.pop_front());
          cpl_valid = 1'b1;
          cpl_write = type_q.pop_front();
          cpl_resp  = resp_q.pop_front();
        end else if (stray_pending) begin
          cpl_valid = 1'b1; cpl_write = 1'b1; cpl_resp = 2'b00;
          stray_pending = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 300) begin @(negedge clk); k++; end
    chk(name, 64'(done), 64'd1);
  endtask

  logic [31:0] exp_addr [4];

  initial begin
    int k;
    exp_addr[0] = 32'h00; exp_addr[1] = 32'h40; exp_addr[2] = 32'h80; exp_addr[3] = 32'hC0;
    rst = 1'b1; enable = 1'b0; req_ready = 1'b1; both_at1 = 1'b0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_addr", 64'(req_addr), 64'd0);
    chk("rst_len", 64'(req_len), 64'd0);

    // 1: full write/read sequence
    step(); enable = 1'b1;
    @(negedge clk); chk("t1_prestart_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    chk("t1_first_valid", 64'(req_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done");
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_busy_done", 64'(busy), 64'd0);
    chk("t1_nreq", 64'(log_addr.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      chk("t1_log_addr", 64'(log_addr[i]), 64'(exp_addr[i % 4]));
      chk("t1_log_wr", 64'(log_wr[i]), 64'(i < 4));
    end
    step(); enable = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t1_done_clear", 64'(done), 64'd0);

    // 2: outstanding cap with completions withheld
    step(2); cpl_hold = 1'b1; enable = 1'b1;
    repeat (12) @(negedge clk);
    chk("t2_two_reqs", 64'(n_wr_hs), 64'd2);
    chk("t2_valid_low", 64'(req_valid), 64'd0);
    chk("t2_ost_full", 64'(dut.u_ost.cnt_o), 64'd2);
    step(); cpl_hold = 1'b0;
    k = 0;
    while (!req_valid && k < 20) begin @(negedge clk); k++; end
    chk("t2_resume", 64'(req_valid), 64'd1);
    wait_done("t2_done");
    step(); enable = 1'b0;

    // 3+4: backpressure stability, then SLVERR on write #1 and a stray completion
    step(2); req_ready = 1'b0; bad_idx = 1; enable = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", 64'(req_valid), 64'd1);
      chk("t3_addr", 64'(req_addr), 64'd0);
      chk("t3_id", 64'(req_id), 64'd0);
      chk("t3_write", 64'(req_write), 64'd1);
      if (i < 4) @(negedge clk);
    end
    step(); req_ready = 1'b1;
    wait_done("t4_done");
    chk("t4_err_cnt1", 64'(err_cnt), 64'd1);
    step(); bad_idx = -1; stray_pending = 1'b1;
    step(3); @(negedge clk);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_err_cnt2", 64'(err_cnt), 64'd2);
    chk("t4_done_held", 64'(done), 64'd1);
    step(); enable = 1'b0;
    step(2); @(negedge clk);
    chk("t4_err_hold_idle", 64'(err_cnt), 64'd2);

    // 5: enable dropped right after the second write accept
    step(); enable = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t5_err_cleared", 64'(err_cnt), 64'd0);
    k = 0;
    while (n_wr_hs < 2 && k < 50) begin step(); k++; end
    enable = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t5_abort_busy", 64'(busy), 64'd1);
    chk("t5_abort_novalid", 64'(req_valid), 64'd0);
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_writes", 64'(n_wr_hs), 64'd2);
    chk("t5_no_reads", 64'(n_rd_hs), 64'd0);
    chk("t5_no_done", 64'(done_seen), 64'd0);
    chk("t5_ost_zero", 64'(dut.u_ost.cnt_o), 64'd0);

    // 6: handshake and completion in the same cycle at ost 1, then reset mid-read
    step(2); cpl_delay = 1; both_at1 = 1'b0; enable = 1'b1;
    k = 0;
    while (!both_at1 && k < 50) begin step(); k++; end
    @(negedge clk);
    chk("t6_same_cycle_seen", 64'(both_at1), 64'd1);
    chk("t6_ost_stays1", 64'(dut.u_ost.cnt_o), 64'd1);
    k = 0;
    while (n_rd_hs < 1 && k < 100) begin step(); k++; end
    chk("t6_in_read", 64'(n_rd_hs >= 1), 64'd1);
    step(); rst = 1'b1; enable = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 64'(req_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_write", 64'(req_write), 64'd0);
    chk("t6_rst_addr", 64'(req_addr), 64'd0);
    chk("t6_rst_id", 64'(req_id), 64'd0);
    chk("t6_rst_ost", 64'(dut.u_ost.cnt_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
